// File: rtl/vga_pkg.sv
// VGA shared package: default 640x480 timing,
// derived totals/starts and checker FSM states.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam bit DEF_SYNC_ACT = 1'b0;

  localparam int DEF_H_TOTAL =
    DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL =
    DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_H_START = DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_START = DEF_V_SYNC + DEF_V_BP;

  localparam int CNT_W  = 10;
  localparam int SUM_W  = 24;
  localparam int FCNT_W = 16;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } vga_state_e;

endpackage

// File: rtl/vga_sync_counter.sv
// Sync edge detector with saturating position counter
// and pulse-width / period checks against expected timing.
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int WIDTH = DEF_H_SYNC,
  parameter int TOTAL = DEF_H_TOTAL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  output logic             rise,
  output logic [CNT_W-1:0] cnt_nx,
  output logic             len_err,
  output logic             wid_err
);

  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SAT    = '1;

  logic             prev;
  logic             fall;
  logic [CNT_W-1:0] cnt;

  // Edge detect, next position, and period/width checks.
  // Reaching the period end without an edge is an overrun,
  // which catches a stuck sync input.
  always_comb begin
    rise    = en & sync & ~prev;
    fall    = en & ~sync & prev;
    cnt_nx  = cnt;
    if (rise)
      cnt_nx = '0;
    else if (en && cnt != SAT)
      cnt_nx = cnt + CNT_W'(1);
    len_err = rise ? (cnt != T_LAST)
                   : (en && cnt == T_LAST);
    wid_err = fall & (cnt != W_LAST);
  end

  // Previous sync level and position, advanced on en only.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= 1'b0;
      cnt  <= '0;
    end else if (en) begin
      prev <= sync;
      cnt  <= cnt_nx;
    end
  end

endmodule

// File: rtl/vga_frame_checker.sv
// VGA sink monitor: recovers pixel position from syncs,
// checks timing, blanking RGB and per-frame checksum.
module vga_frame_checker
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_ACT = DEF_SYNC_ACT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_en,
  input  logic [2:0]        vga_rgb,
  input  logic              vga_hsync,
  input  logic              vga_vsync,
  output logic              locked,
  output logic              pix_valid,
  output logic [CNT_W-1:0]  pix_x,
  output logic [CNT_W-1:0]  pix_y,
  output logic [2:0]        pix_rgb,
  output logic              frame_done,
  output logic [SUM_W-1:0]  frame_sum,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              err_hsync,
  output logic              err_vsync,
  output logic              err_blank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] H_FIRST =
    CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_LAST =
    CNT_W'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_FIRST =
    CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_LAST =
    CNT_W'(V_SYNC + V_BP + V_ACTIVE - 1);

  logic             hs, vs;
  logic             h_rise, v_rise;
  logic             h_len, h_wid, v_len, v_wid;
  logic             h_bad, v_bad;
  logic [CNT_W-1:0] hcnt, vcnt;
  logic             active;
  vga_state_e       state_q, state_nx;
  logic             frame_ok, set_eh, set_ev;
  logic [SUM_W-1:0] acc;

  assign hs = (vga_hsync == SYNC_ACT);
  assign vs = (vga_vsync == SYNC_ACT);

  vga_sync_counter #(
    .WIDTH (H_SYNC),
    .TOTAL (H_TOTAL)
  ) u_hcnt (
    .clk     (clk),
    .reset   (reset),
    .en      (pix_en),
    .sync    (hs),
    .rise    (h_rise),
    .cnt_nx  (hcnt),
    .len_err (h_len),
    .wid_err (h_wid)
  );

  // Vertical counter steps once per line, on hsync edges.
  vga_sync_counter #(
    .WIDTH (V_SYNC),
    .TOTAL (V_TOTAL)
  ) u_vcnt (
    .clk     (clk),
    .reset   (reset),
    .en      (h_rise),
    .sync    (vs),
    .rise    (v_rise),
    .cnt_nx  (vcnt),
    .len_err (v_len),
    .wid_err (v_wid)
  );

  assign h_bad  = h_len | h_wid;
  assign v_bad  = v_len | v_wid;
  assign active = (hcnt >= H_FIRST) && (hcnt <= H_LAST) &&
                  (vcnt >= V_FIRST) && (vcnt <= V_LAST);
  assign locked = (state_q == LOCKED);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= SEARCH;
    else       state_q <= state_nx;
  end

  // Lock FSM: timing checks matter only once acquiring.
  always_comb begin
    state_nx = state_q;
    frame_ok = 1'b0;
    set_eh   = 1'b0;
    set_ev   = 1'b0;
    unique case (state_q)
      SEARCH: begin
        if (v_rise) state_nx = ACQUIRE;
      end
      ACQUIRE: begin
        if (h_bad || v_bad) begin
          state_nx = SEARCH;
        end else if (v_rise) begin
          state_nx = LOCKED;
          frame_ok = 1'b1;
        end
      end
      LOCKED: begin
        if (h_bad || v_bad) begin
          state_nx = SEARCH;
          set_eh   = h_bad;
          set_ev   = v_bad;
        end else if (v_rise) begin
          frame_ok = 1'b1;
        end
      end
      default: state_nx = SEARCH;
    endcase
  end

  // Checksum, frame reporting, pixel outputs, error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      frame_done <= 1'b0;
      frame_sum  <= '0;
      frame_cnt  <= '0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_rgb    <= '0;
      err_hsync  <= 1'b0;
      err_vsync  <= 1'b0;
      err_blank  <= 1'b0;
    end else begin
      frame_done <= frame_ok;
      if (frame_ok) begin
        frame_sum <= acc;
        frame_cnt <= frame_cnt + FCNT_W'(1);
      end
      if (v_rise)
        acc <= '0;
      else if (pix_en && active)
        acc <= acc + SUM_W'(vga_rgb);
      pix_valid <= pix_en && active && locked;
      if (pix_en && active && locked) begin
        pix_x   <= hcnt - H_FIRST;
        pix_y   <= vcnt - V_FIRST;
        pix_rgb <= vga_rgb;
      end
      if (set_eh) err_hsync <= 1'b1;
      if (set_ev) err_vsync <= 1'b1;
      if (locked && pix_en && !active && vga_rgb != 3'b000)
        err_blank <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_frame_checker.sv
// Directed bench for vga_frame_checker using a reduced
// 8x4 video mode so whole frames stay short.
module tb_vga_frame_checker;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int HST = HS + HB;
  localparam int VST = VS + VB;
  localparam bit SA = 1'b0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_en = 1'b0;
  logic [2:0]  vga_rgb = 3'b000;
  logic        vga_hsync = ~SA;
  logic        vga_vsync = ~SA;
  logic        locked, pix_valid, frame_done;
  logic [9:0]  pix_x, pix_y;
  logic [2:0]  pix_rgb;
  logic [23:0] frame_sum;
  logic [15:0] frame_cnt;
  logic        err_hsync, err_vsync, err_blank;

  int vecs = 0;
  int errs = 0;
  int pulses = 0;

  vga_frame_checker #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .SYNC_ACT (SA)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_en     (pix_en),
    .vga_rgb    (vga_rgb),
    .vga_hsync  (vga_hsync),
    .vga_vsync  (vga_vsync),
    .locked     (locked),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_rgb    (pix_rgb),
    .frame_done (frame_done),
    .frame_sum  (frame_sum),
    .frame_cnt  (frame_cnt),
    .err_hsync  (err_hsync),
    .err_vsync  (err_vsync),
    .err_blank  (err_blank)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done) pulses++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time %0t limit reached", $time);
    $fatal(1, "watchdog");
  end

  // One pixel strobe, then one idle clock.
  task automatic px(input logic hs, input logic vs,
                    input logic [2:0] rgb);
    @(negedge clk);
    vga_hsync = hs ? SA : ~SA;
    vga_vsync = vs ? SA : ~SA;
    vga_rgb   = rgb;
    pix_en    = 1'b1;
    @(negedge clk);
    pix_en    = 1'b0;
  endtask

  task automatic send_line(input int v, input int hsw,
                           input logic [2:0] act,
                           input int bpos,
                           input logic [2:0] brgb,
                           input int h0, input int h1);
    for (int h = h0; h <= h1; h++) begin
      logic       in_act;
      logic [2:0] c;
      in_act = (h >= HST) && (h < HST + HA) &&
               (v >= VST) && (v < VST + VA);
      c = in_act ? act : ((h == bpos) ? brgb : 3'b000);
      px(h < hsw, v < VS, c);
    end
  endtask

  task automatic send_frame(input int nl,
                            input logic [2:0] act);
    for (int v = 0; v < nl; v++)
      send_line(v, HS, act, -1, 3'b000, 0, HT - 1);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) px(1'b0, 1'b0, 3'b000);
    reset = 1'b0;
    vecs++;
    if (locked !== 1'b0) begin
      errs++; $display("FAIL rst_locked: got %b want 0", locked);
    end
    vecs++;
    if ({pix_valid, frame_done} !== 2'b00) begin
      errs++; $display("FAIL rst_strobes: got %b want 00",
                       {pix_valid, frame_done});
    end
    vecs++;
    if (frame_sum !== 24'd0 || frame_cnt !== 16'd0) begin
      errs++; $display("FAIL rst_frame: sum %0d cnt %0d want 0 0",
                       frame_sum, frame_cnt);
    end
    vecs++;
    if ({pix_x, pix_y, pix_rgb} !== 23'd0) begin
      errs++; $display("FAIL rst_pix: x %0d y %0d rgb %0d want 0",
                       pix_x, pix_y, pix_rgb);
    end
    repeat (2 * HT + 3) px(1'b0, 1'b0, 3'b101);
    vecs++;
    if ({err_hsync, err_vsync, err_blank} !== 3'b000) begin
      errs++; $display("FAIL idle_errs: got %b want 000",
                       {err_hsync, err_vsync, err_blank});
    end
    vecs++;
    if (locked !== 1'b0) begin
      errs++; $display("FAIL idle_locked: got %b want 0", locked);
    end
  endtask

  task automatic test_lock;
    send_frame(VT, 3'b111);
    send_frame(VT, 3'b111);
    vecs++;
    if (locked !== 1'b1) begin
      errs++; $display("FAIL lock_b: got %b want 1", locked);
    end
    vecs++;
    if (frame_cnt !== 16'd1) begin
      errs++; $display("FAIL lock_cnt: got %0d want 1", frame_cnt);
    end
    vecs++;
    if ({pix_x, pix_y, pix_rgb} !== {10'd7, 10'd3, 3'd7}) begin
      errs++; $display("FAIL lock_hold: x %0d y %0d rgb %0d want 7 3 7",
                       pix_x, pix_y, pix_rgb);
    end
    send_frame(VT, 3'b111);
    vecs++;
    if (frame_sum !== 24'd224) begin
      errs++; $display("FAIL lock_sum: got %0d want 224", frame_sum);
    end
    vecs++;
    if (frame_cnt !== 16'd2 || pulses !== 2) begin
      errs++; $display("FAIL lock_cnt2: cnt %0d pulses %0d want 2 2",
                       frame_cnt, pulses);
    end
  endtask

  task automatic test_hsync_width;
    for (int v = 0; v < 5; v++)
      send_line(v, HS, 3'b111, -1, 3'b000, 0, HT - 1);
    send_line(5, HS - 1, 3'b111, -1, 3'b000, 0, 1);
    vecs++;
    if ({locked, err_hsync} !== 2'b10) begin
      errs++; $display("FAIL hsw_pre: lock/err %b want 10",
                       {locked, err_hsync});
    end
    send_line(5, HS - 1, 3'b111, -1, 3'b000, 2, 2);
    vecs++;
    if ({locked, err_hsync} !== 2'b01) begin
      errs++; $display("FAIL hsw_fall: lock/err %b want 01",
                       {locked, err_hsync});
    end
    send_line(5, HS, 3'b111, -1, 3'b000, 3, HT - 1);
    for (int v = 6; v < VT; v++)
      send_line(v, HS, 3'b111, -1, 3'b000, 0, HT - 1);
    vecs++;
    if (err_vsync !== 1'b0 || frame_cnt !== 16'd3) begin
      errs++; $display("FAIL hsw_side: ev %b cnt %0d want 0 3",
                       err_vsync, frame_cnt);
    end
    send_frame(VT, 3'b111);
    send_frame(VT, 3'b111);
    vecs++;
    if ({locked, err_hsync} !== 2'b11) begin
      errs++; $display("FAIL hsw_relock: lock/err %b want 11",
                       {locked, err_hsync});
    end
    vecs++;
    if (frame_cnt !== 16'd4 || frame_sum !== 24'd224) begin
      errs++; $display("FAIL hsw_frame: cnt %0d sum %0d want 4 224",
                       frame_cnt, frame_sum);
    end
  endtask

  task automatic test_frame_length;
    send_frame(VT - 1, 3'b010);
    send_line(0, HS, 3'b111, -1, 3'b000, 0, 0);
    vecs++;
    if ({locked, err_vsync, frame_done} !== 3'b010) begin
      errs++; $display("FAIL vlen_edge: lock/ev/done %b want 010",
                       {locked, err_vsync, frame_done});
    end
    send_line(0, HS, 3'b111, -1, 3'b000, 1, HT - 1);
    for (int v = 1; v < VT; v++)
      send_line(v, HS, 3'b111, -1, 3'b000, 0, HT - 1);
    vecs++;
    if (frame_sum !== 24'd224 || frame_cnt !== 16'd5) begin
      errs++; $display("FAIL vlen_keep: sum %0d cnt %0d want 224 5",
                       frame_sum, frame_cnt);
    end
    vecs++;
    if (pulses !== 5) begin
      errs++; $display("FAIL vlen_pulses: got %0d want 5", pulses);
    end
    send_frame(VT, 3'b011);
    send_frame(VT, 3'b111);
    vecs++;
    if (locked !== 1'b1 || frame_sum !== 24'd96) begin
      errs++; $display("FAIL vlen_relock: lock %b sum %0d want 1 96",
                       locked, frame_sum);
    end
    vecs++;
    if (frame_cnt !== 16'd6) begin
      errs++; $display("FAIL vlen_cnt: got %0d want 6", frame_cnt);
    end
  endtask

  task automatic test_blank_pixel;
    for (int v = 0; v < 4; v++)
      send_line(v, HS, 3'b101, -1, 3'b000, 0, HT - 1);
    send_line(4, HS, 3'b101, 1, 3'b001, 0, 0);
    vecs++;
    if (err_blank !== 1'b0) begin
      errs++; $display("FAIL blank_pre: got %b want 0", err_blank);
    end
    send_line(4, HS, 3'b101, 1, 3'b001, 1, 1);
    vecs++;
    if ({locked, err_blank} !== 2'b11) begin
      errs++; $display("FAIL blank_set: lock/eb %b want 11",
                       {locked, err_blank});
    end
    send_line(4, HS, 3'b101, 1, 3'b001, 2, HT - 1);
    for (int v = 5; v < VT; v++)
      send_line(v, HS, 3'b101, -1, 3'b000, 0, HT - 1);
    send_line(0, HS, 3'b110, -1, 3'b000, 0, 0);
    vecs++;
    if (frame_done !== 1'b1 || frame_cnt !== 16'd8) begin
      errs++; $display("FAIL blank_done: done %b cnt %0d want 1 8",
                       frame_done, frame_cnt);
    end
    vecs++;
    if (frame_sum !== 24'd160) begin
      errs++; $display("FAIL blank_sum: got %0d want 160", frame_sum);
    end
    send_line(0, HS, 3'b110, -1, 3'b000, 1, HT - 1);
    for (int v = 1; v < 3; v++)
      send_line(v, HS, 3'b110, -1, 3'b000, 0, HT - 1);
    send_line(3, HS, 3'b110, -1, 3'b000, 0, HST - 1);
    vecs++;
    if (pix_valid !== 1'b0) begin
      errs++; $display("FAIL px_porch: valid %b want 0", pix_valid);
    end
    send_line(3, HS, 3'b110, -1, 3'b000, HST, HST);
    vecs++;
    if ({pix_valid, pix_x, pix_y, pix_rgb} !==
        {1'b1, 10'd0, 10'd0, 3'd6}) begin
      errs++; $display("FAIL px_first: v %b x %0d y %0d rgb %0d want 1 0 0 6",
                       pix_valid, pix_x, pix_y, pix_rgb);
    end
    @(negedge clk);
    vecs++;
    if ({pix_valid, pix_x} !== {1'b0, 10'd0}) begin
      errs++; $display("FAIL px_hold: v %b x %0d want 0 0",
                       pix_valid, pix_x);
    end
    send_line(3, HS, 3'b110, -1, 3'b000, HST + 1, HST + 1);
    vecs++;
    if ({pix_valid, pix_x} !== {1'b1, 10'd1}) begin
      errs++; $display("FAIL px_second: v %b x %0d want 1 1",
                       pix_valid, pix_x);
    end
    send_line(3, HS, 3'b110, -1, 3'b000, HST + 2, HT - 1);
    for (int v = 4; v < VT; v++)
      send_line(v, HS, 3'b110, -1, 3'b000, 0, HT - 1);
  endtask

  task automatic test_reset_mid;
    for (int v = 0; v < 4; v++)
      send_line(v, HS, 3'b111, -1, 3'b000, 0, HT - 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vecs++;
    if ({locked, err_hsync, err_vsync, err_blank} !== 4'b0000) begin
      errs++; $display("FAIL mid_flags: got %b want 0000",
                       {locked, err_hsync, err_vsync, err_blank});
    end
    vecs++;
    if (frame_cnt !== 16'd0 || frame_sum !== 24'd0) begin
      errs++; $display("FAIL mid_frame: cnt %0d sum %0d want 0 0",
                       frame_cnt, frame_sum);
    end
    vecs++;
    if ({pix_valid, pix_x, pix_y, pix_rgb} !== 24'd0) begin
      errs++; $display("FAIL mid_pix: x %0d y %0d rgb %0d want 0",
                       pix_x, pix_y, pix_rgb);
    end
    for (int v = 4; v < VT; v++)
      send_line(v, HS, 3'b111, -1, 3'b000, 0, HT - 1);
    send_frame(VT, 3'b110);
    vecs++;
    if (frame_cnt !== 16'd0 || locked !== 1'b0) begin
      errs++; $display("FAIL mid_acq: cnt %0d lock %b want 0 0",
                       frame_cnt, locked);
    end
    send_frame(VT, 3'b111);
    vecs++;
    if (frame_cnt !== 16'd1 || frame_sum !== 24'd192) begin
      errs++; $display("FAIL mid_relock: cnt %0d sum %0d want 1 192",
                       frame_cnt, frame_sum);
    end
    vecs++;
    if (locked !== 1'b1 || pulses !== 10) begin
      errs++; $display("FAIL mid_lock: lock %b pulses %0d want 1 10",
                       locked, pulses);
    end
  endtask

  initial begin
    test_reset;
    test_lock;
    test_hsync_width;
    test_frame_length;
    test_blank_pixel;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
